// File: rtl/debug_pkg.sv
// Shared definitions for the debug response path: FSM encoding, widths and
// the decoder clock-control command codes used by both RTL and host tests.
package debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } dbg_state_e;

  localparam int DBG_BYTE_W = 8;
  localparam int DBG_WORD_W = 32;
  localparam int DBG_SIZE_W = 2;

  localparam logic [5:0] DBG_CMD_CLK_CTL0 = 6'b111000;
  localparam logic [5:0] DBG_CMD_CLK_CTL1 = 6'b111111;

endpackage

// File: rtl/debug_resp_tx_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses o_tick
// on the last cycle of each serial bit.
module baud_tick #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clock,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clock) begin
    if (!reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/debug_resp_tx.sv
// Debug-response UART transmitter: latches a decoder word and sends size+1
// bytes LSB-first as back-to-back 8N1 frames.
module debug_resp_tx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DBG_WORD_W-1:0] result,
  input  logic [DBG_SIZE_W-1:0] size,
  output logic                  busy,
  output logic                  done,
  output logic                  tx
);

  dbg_state_e            r_state, w_state_nxt;
  logic [DBG_WORD_W-1:0] r_word, w_word_nxt;
  logic [DBG_SIZE_W-1:0] r_rem, w_rem_nxt;
  logic [2:0]            r_bit, w_bit_nxt, w_bit_inc;
  logic                  r_tx, w_tx_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_accept;
  logic                  w_tick;
  logic [DBG_BYTE_W-1:0] w_byte;

  assign w_byte    = r_word[DBG_BYTE_W-1:0];
  assign w_bit_inc = r_bit + 3'd1;

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock  (clock),
    .reset  (reset),
    .i_en   (r_state != ST_IDLE),
    .i_clr  (w_accept),
    .o_tick (w_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_rem   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_rem   <= w_rem_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Outputs are computed one cycle ahead so tx/busy/done come straight from flops.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_rem_nxt   = r_rem;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_START;
          w_word_nxt  = result;
          w_rem_nxt   = size;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = w_byte[0];
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = w_bit_inc;
            w_tx_nxt  = w_byte[w_bit_inc];
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_rem != '0) begin
            w_state_nxt = ST_START;
            w_rem_nxt   = r_rem - DBG_SIZE_W'(1);
            w_word_nxt  = r_word >> DBG_BYTE_W;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule
